// File: rtl/decoder3x8_pkg.sv
// Shared types and widths for the 3-to-8 strobe decoder.
package decoder3x8_pkg;

    localparam int CNT_W    = 5;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec3x8.sv
// Pure combinational 3-bit binary to 8-bit one-hot decoder.
module onehot_dec3x8
    import decoder3x8_pkg::*;
(
    input  logic [2:0]          code,
    output logic [ONEHOT_W-1:0] onehot
);

    // Set exactly the bit selected by the code.
    always_comb begin
        // NOTE: assigning a default first means every path writes onehot, so no latch is inferred.
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder3x8_strobe.sv
// Accepts a 3-bit code over valid/ready and drives its one-hot line as a
// timed strobe: PULSE_LEN cycles of one-hot, then GAP_LEN cycles of zero.
module decoder3x8_strobe
    import decoder3x8_pkg::*;
#(
    parameter int PULSE_LEN  = 4,
    parameter int GAP_LEN    = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_code,
    output logic [ONEHOT_W-1:0] data_out,
    output logic [2:0]          out_code,
    output logic                busy,
    output logic [7:0]          strobe_cnt
);

    generate
        if (PULSE_LEN < 1 || PULSE_LEN > 16) begin : g_bad_pulse_len
            $error("decoder3x8_strobe: PULSE_LEN must be in 1..16");
        end
        if (GAP_LEN < 0 || GAP_LEN > 16) begin : g_bad_gap_len
            $error("decoder3x8_strobe: GAP_LEN must be in 0..16");
        end
    endgenerate

    // Counter reload values; the counter runs down to zero inclusive.
    localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit               NO_GAP       = (GAP_LEN == 0);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ONEHOT_W-1:0]   onehot_q, onehot_d;
    logic [ONEHOT_W-1:0]   dec_onehot;
    logic [2:0]            code_d;
    logic                  cnt_zero;
    logic                  accept;
    logic                  strobe_done;

    onehot_dec3x8 u_dec (
        .code   (in_code),
        .onehot (dec_onehot)
    );

    assign cnt_zero = (cnt_q == '0);

    // Ready depends only on registered state and in_en, never on in_valid.
    assign in_ready = in_en && ((state_q == IDLE)
                             || (state_q == GAP   && cnt_zero)
                             || (state_q == DRIVE && cnt_zero && NO_GAP));

    assign accept = in_valid && in_ready;

    // Polarity is a constant, so data_out stays a registered value.
    assign data_out = ACTIVE_LOW ? ~onehot_q : onehot_q;

    // Next-state, counter and strobe register contents.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        onehot_d    = onehot_q;
        code_d      = out_code;
        strobe_done = 1'b0;

        case (state_q)
            IDLE: begin
                onehot_d = '0;
            end
            DRIVE: begin
                if (cnt_zero) begin
                    strobe_done = 1'b1;
                    onehot_d    = '0;
                    if (NO_GAP) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                onehot_d = '0;
            end
        endcase

        // Accept is only possible in IDLE or on the final DRIVE/GAP cycle,
        // so a new strobe overrides whatever the state would do next. Loading
        // straight from the decoder keeps back-to-back strobes glitch-free.
        if (accept) begin
            state_d  = DRIVE;
            cnt_d    = PULSE_RELOAD;
            onehot_d = dec_onehot;
            code_d   = in_code;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            onehot_q   <= '0;
            out_code   <= '0;
            busy       <= 1'b0;
            strobe_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            out_code <= code_d;
            busy     <= (state_d != IDLE);
            if (strobe_done) begin
                strobe_cnt <= strobe_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_decoder3x8_strobe.sv
// Scoreboard bench for decoder3x8_strobe across three parameter sets:
//   u0: PULSE_LEN=4 GAP_LEN=1, u1: PULSE_LEN=1 GAP_LEN=0, u2: PULSE_LEN=4 GAP_LEN=1 ACTIVE_LOW.
module tb_decoder3x8_strobe;

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
        int         len;
        int         gap;   // idle cycles expected before this strobe; -1 = don't care
    } exp_t;

    logic       clk;
    logic       rst_n    [3];
    logic       in_en    [3];
    logic       in_valid [3];
    logic       in_ready [3];
    logic [2:0] in_code  [3];
    logic [7:0] dout     [3];
    logic [2:0] oc       [3];
    logic       busy     [3];
    logic [7:0] scnt     [3];

    exp_t sb [3][$];

    int checks = 0;
    int errors = 0;

    decoder3x8_strobe #(.PULSE_LEN(4), .GAP_LEN(1), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_en(in_en[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_code(in_code[0]), .data_out(dout[0]),
        .out_code(oc[0]), .busy(busy[0]), .strobe_cnt(scnt[0])
    );

    decoder3x8_strobe #(.PULSE_LEN(1), .GAP_LEN(0), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .in_en(in_en[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_code(in_code[1]), .data_out(dout[1]),
        .out_code(oc[1]), .busy(busy[1]), .strobe_cnt(scnt[1])
    );

    decoder3x8_strobe #(.PULSE_LEN(4), .GAP_LEN(1), .ACTIVE_LOW(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .in_en(in_en[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_code(in_code[2]), .data_out(dout[2]),
        .out_code(oc[2]), .busy(busy[2]), .strobe_cnt(scnt[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] idle_val(input int i);
        return (i == 2) ? 8'hFF : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for one accepted code on instance i.
    task automatic push(input int i, input logic [2:0] c, input int gap);
        exp_t e;
        e.data = 8'd1 << c;
        if (i == 2) e.data = ~e.data;
        e.code = c;
        e.len  = (i == 1) ? 1 : 4;
        e.gap  = gap;
        sb[i].push_back(e);
    endtask

    // Present a code, wait (bounded) for ready, and complete the handshake.
    task automatic send(input int i, input logic [2:0] c, input int gap,
                        input bit hold, output int waits);
        waits       = 0;
        in_valid[i] = 1'b1;
        in_code[i]  = c;
        while (!in_ready[i] && waits < 50) begin
            tick();
            waits++;
        end
        if (!in_ready[i]) begin
            check("send_ready_timeout", 32'd0, 32'd1);
        end else begin
            push(i, c, gap);
        end
        tick();
        if (!hold) in_valid[i] = 1'b0;
    endtask

    // Hold valid and stream n consecutive codes starting at 'start'.
    task automatic stream(input int i, input int n, input int start);
        int total = 0;
        in_valid[i] = 1'b1;
        for (int k = 0; k < n; k++) begin
            int w = 0;
            in_code[i] = 3'((start + k) % 8);
            while (!in_ready[i] && w < 50) begin
                tick();
                w++;
            end
            if (!in_ready[i]) begin
                check("stream_ready_timeout", 32'd0, 32'd1);
                break;
            end
            total += w;
            push(i, in_code[i], (k == 0) ? -1 : 0);
            tick();
        end
        in_valid[i] = 1'b0;
        check("stream_stall_cycles", total, 32'd0);
    endtask

    // Monitor: collect each run of a constant non-idle value as one strobe,
    // then compare it with the oldest expected strobe for that instance.
    initial begin
        int         run_len  [3];
        int         run_gap  [3];
        int         gap_cnt  [3];
        logic [7:0] run_val  [3];
        logic [2:0] run_code [3];
        exp_t       e;
        for (int i = 0; i < 3; i++) begin
            run_len[i]  = 0;
            run_gap[i]  = -1;
            gap_cnt[i]  = -1;
            run_val[i]  = '0;
            run_code[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n[i]) begin
                    run_len[i] = 0;
                    gap_cnt[i] = -1;
                end else begin
                    if (run_len[i] > 0 && dout[i] != run_val[i]) begin
                        if (sb[i].size() == 0) begin
                            check("unexpected_strobe", {24'd0, run_val[i]}, {24'd0, idle_val(i)});
                        end else begin
                            e = sb[i].pop_front();
                            check("strobe_data", {24'd0, run_val[i]}, {24'd0, e.data});
                            check("strobe_code", {29'd0, run_code[i]}, {29'd0, e.code});
                            check("strobe_len", run_len[i], e.len);
                            if (e.gap >= 0) check("strobe_gap", run_gap[i], e.gap);
                        end
                        run_len[i] = 0;
                        gap_cnt[i] = 0;
                    end
                    if (dout[i] != idle_val(i)) begin
                        if (run_len[i] == 0) begin
                            run_val[i]  = dout[i];
                            run_code[i] = oc[i];
                            run_gap[i]  = gap_cnt[i];
                            run_len[i]  = 1;
                        end else begin
                            run_len[i]++;
                        end
                    end else if (gap_cnt[i] >= 0) begin
                        gap_cnt[i]++;
                    end
                end
            end
        end
    end

    initial begin
        int w;
        int ready_hits;
        for (int i = 0; i < 3; i++) begin
            rst_n[i]    = 1'b0;
            in_en[i]    = 1'b0;
            in_valid[i] = 1'b0;
            in_code[i]  = 3'd0;
        end

        // Reset state.
        repeat (3) tick();
        check("rst_dout0",  {24'd0, dout[0]}, 32'h00);
        check("rst_dout2",  {24'd0, dout[2]}, 32'hFF);
        check("rst_code0",  {29'd0, oc[0]},   32'd0);
        check("rst_busy0",  {31'd0, busy[0]}, 32'd0);
        check("rst_scnt0",  {24'd0, scnt[0]}, 32'd0);
        check("rst_ready0", {31'd0, in_ready[0]}, 32'd0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) in_en[i] = 1'b1;
        #1;
        check("idle_ready0", {31'd0, in_ready[0]}, 32'd1);

        // Single strobe of code 2, visible one cycle after accept.
        send(0, 3'd2, -1, 1'b0, w);
        check("first_dout0", {24'd0, dout[0]}, 32'h04);
        check("drive_busy0", {31'd0, busy[0]}, 32'd1);
        check("drive_ready0", {31'd0, in_ready[0]}, 32'd0);
        repeat (6) tick();
        check("single_scnt0", {24'd0, scnt[0]}, 32'd1);
        check("single_code0", {29'd0, oc[0]},   32'd2);
        check("single_dout0", {24'd0, dout[0]}, 32'h00);
        check("single_busy0", {31'd0, busy[0]}, 32'd0);

        // Back-to-back with valid held: 7 then 0; ready only in the GAP cycle.
        send(0, 3'd7, -1, 1'b1, w);
        send(0, 3'd0, 1, 1'b0, w);
        check("b2b_wait_cycles", w, 32'd4);
        repeat (7) tick();
        check("b2b_scnt0", {24'd0, scnt[0]}, 32'd3);
        check("b2b_code0", {29'd0, oc[0]},   32'd0);

        // No-gap, single-cycle strobes walking codes 0..7.
        stream(1, 8, 0);
        repeat (3) tick();
        check("walk_scnt1", {24'd0, scnt[1]}, 32'd8);
        check("walk_code1", {29'd0, oc[1]},   32'd7);

        // Enable drops during DRIVE cycle 2 of code 5: strobe completes, no new accept.
        send(0, 3'd5, -1, 1'b0, w);
        tick();
        in_en[0]    = 1'b0;
        in_valid[0] = 1'b1;
        in_code[0]  = 3'd1;
        #1;
        ready_hits = 0;
        for (int k = 0; k < 8; k++) begin
            if (in_ready[0]) ready_hits++;
            tick();
        end
        check("en_low_ready_hits", ready_hits, 32'd0);
        check("en_low_scnt0", {24'd0, scnt[0]}, 32'd4);
        check("en_low_busy0", {31'd0, busy[0]}, 32'd0);
        in_valid[0] = 1'b0;
        in_en[0]    = 1'b1;
        tick();

        // Reset mid-DRIVE of code 6 kills the strobe without counting it.
        send(0, 3'd6, -1, 1'b0, w);
        tick();
        check("mid_dout0", {24'd0, dout[0]}, 32'h40);
        check("mid_scnt0", {24'd0, scnt[0]}, 32'd4);
        rst_n[0] = 1'b0;
        sb[0].delete();
        #1;
        check("async_rst_dout0", {24'd0, dout[0]}, 32'h00);
        check("async_rst_busy0", {31'd0, busy[0]}, 32'd0);
        tick();
        rst_n[0] = 1'b1;
        repeat (6) tick();
        check("killed_scnt0", {24'd0, scnt[0]}, 32'd0);
        check("killed_dout0", {24'd0, dout[0]}, 32'h00);

        // strobe_cnt wraps after 256 completed strobes.
        rst_n[1] = 1'b0;
        tick();
        rst_n[1] = 1'b1;
        tick();
        stream(1, 255, 0);
        repeat (3) tick();
        check("wrap_scnt_255", {24'd0, scnt[1]}, 32'd255);
        stream(1, 1, 7);
        repeat (3) tick();
        check("wrap_scnt_0", {24'd0, scnt[1]}, 32'd0);

        // Active-low polarity.
        check("al_idle", {24'd0, dout[2]}, 32'hFF);
        send(2, 3'd3, -1, 1'b0, w);
        check("al_strobe", {24'd0, dout[2]}, 32'hF7);
        repeat (6) tick();
        check("al_after", {24'd0, dout[2]}, 32'hFF);
        check("al_scnt2", {24'd0, scnt[2]}, 32'd1);

        // Every expected strobe must have been observed.
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            check("sb_drained", sb[i].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
